// File: rtl/instr_mem_loader.sv
`default_nettype none
// ============================================================================
// Module   : instr_mem_loader
// Purpose  : Writer side of the byte-addressed, little-endian instruction
//            memory. Accepts 32-bit program words on a valid/ready stream and
//            writes each one as four consecutive byte writes (bits [7:0] at
//            the lowest address). Holds the CPU in reset while a load is in
//            progress and pulses done_o for one cycle when it finishes.
// Ports    : clk, rst_n (sync, active-low)
//            start_i, base_addr_i, word_count_i : load request (IDLE only)
//            word_valid_i, word_i, word_ready_o : program word stream
//            mem_we_o, mem_addr_o, mem_wdata_o  : byte write port
//            busy_o, done_o, cpu_hold_o         : status
// Revision : 1.0 - initial release
// ============================================================================
module instr_mem_loader #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 32,  // only 32 (four bytes per word) supported
  parameter int BYTE_WIDTH    = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start_i,
  input  logic [ADDRESS_WIDTH-1:0] base_addr_i,
  input  logic [ADDRESS_WIDTH-1:0] word_count_i,
  input  logic                     word_valid_i,
  input  logic [DATA_WIDTH-1:0]    word_i,
  output logic                     word_ready_o,
  output logic                     mem_we_o,
  output logic [ADDRESS_WIDTH-1:0] mem_addr_o,
  output logic [BYTE_WIDTH-1:0]    mem_wdata_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     cpu_hold_o
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_WORD = 2'd1,
    ST_WRITE     = 2'd2,
    ST_DONE      = 2'd3
  } state_t;

  localparam logic [ADDRESS_WIDTH-1:0] C_ONE      = ADDRESS_WIDTH'(1);
  localparam logic [1:0]               C_LAST_IDX = 2'd3;

  state_t                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [ADDRESS_WIDTH-1:0] count_q, count_d;
  logic [1:0]               idx_q, idx_d;
  logic [DATA_WIDTH-1:0]    word_q, word_d;

  // Outputs are registered copies of the decode of the *next* state, so
  // they line up exactly with the state they describe.
  logic                     ready_q, ready_d;
  logic                     we_q, we_d;
  logic [ADDRESS_WIDTH-1:0] maddr_q, maddr_d;
  logic [BYTE_WIDTH-1:0]    wdata_q, wdata_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic [BYTE_WIDTH-1:0]    byte_sel;

  // Next-state and datapath
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    idx_d   = idx_q;
    word_d  = word_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          if (word_count_i != '0) begin
            addr_d  = base_addr_i;
            count_d = word_count_i;
            state_d = ST_WAIT_WORD;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_WAIT_WORD: begin
        // ready is implied by being in this state
        if (word_valid_i) begin
          word_d  = word_i;
          idx_d   = 2'd0;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        addr_d = addr_q + C_ONE;  // wraps naturally at the array size
        idx_d  = idx_q + 2'd1;
        if (idx_q == C_LAST_IDX) begin
          count_d = count_q - C_ONE;
          state_d = (count_q == C_ONE) ? ST_DONE : ST_WAIT_WORD;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Little-endian byte lane for the upcoming write cycle
  always_comb begin
    byte_sel = '0;
    case (idx_d)
      2'd0: byte_sel = word_d[BYTE_WIDTH-1:0];
      2'd1: byte_sel = word_d[2*BYTE_WIDTH-1:BYTE_WIDTH];
      2'd2: byte_sel = word_d[3*BYTE_WIDTH-1:2*BYTE_WIDTH];
      2'd3: byte_sel = word_d[4*BYTE_WIDTH-1:3*BYTE_WIDTH];
      default: byte_sel = '0;
    endcase
  end

  always_comb begin
    ready_d = (state_d == ST_WAIT_WORD);
    we_d    = (state_d == ST_WRITE);
    maddr_d = we_d ? addr_d : '0;
    wdata_d = we_d ? byte_sel : '0;
    busy_d  = ready_d | we_d;
    done_d  = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      count_q <= '0;
      idx_q   <= '0;
      word_q  <= '0;
      ready_q <= 1'b0;
      we_q    <= 1'b0;
      maddr_q <= '0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      ready_q <= ready_d;
      we_q    <= we_d;
      maddr_q <= maddr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign word_ready_o = ready_q;
  assign mem_we_o     = we_q;
  assign mem_addr_o   = maddr_q;
  assign mem_wdata_o  = wdata_q;
  assign busy_o       = busy_q;
  assign cpu_hold_o   = busy_q;
  assign done_o       = done_q;

endmodule
`default_nettype wire

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
- Writer side of the byte-addressed, little-endian instruction memory.
- Accepts 32-bit program words over a valid/ready stream and writes each word as four byte writes into the instruction memory array. Word bits [7:0] go to the base address, bits [31:24] to base+3.
- Runs before CPU execution. It holds the core in reset while loading and signals completion with a one-cycle pulse.

Parameters:
- ADDRESS_WIDTH, 8, byte address width of the instruction memory; the array is 2**ADDRESS_WIDTH bytes.
- DATA_WIDTH, 32, program word width; only 32 is supported (4 bytes per word).
- BYTE_WIDTH, 8, width of each memory write.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- start_i  input  1  one-cycle request to begin a load; sampled only in IDLE.
- base_addr_i  input  ADDRESS_WIDTH  byte address of the first word; latched on accepted start.
- word_count_i  input  ADDRESS_WIDTH  number of words to load; latched on accepted start.
- word_valid_i  input  1  source presents a program word.
- word_i  input  DATA_WIDTH  program word.
- word_ready_o  output  1  loader accepts a word this cycle.
- mem_we_o  output  1  byte write strobe to instruction memory.
- mem_addr_o  output  ADDRESS_WIDTH  byte write address.
- mem_wdata_o  output  BYTE_WIDTH  byte write data.
- busy_o  output  1  a load is in progress (WAIT_WORD or WRITE).
- done_o  output  1  one-cycle pulse when a load completes.
- cpu_hold_o  output  1  high while busy; keeps the CPU in reset.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - FSM goes to IDLE.
  - All outputs are 0; addr pointer, byte index, word counter and word register are cleared.
  - Reset mid-load aborts immediately. No further writes occur, and bytes already written stay in memory.
- FSM states: IDLE, WAIT_WORD, WRITE, DONE.
- IDLE:
  - start_i=1 with word_count_i!=0: latch base_addr_i into the addr pointer and word_count_i into the word counter; go to WAIT_WORD.
  - start_i=1 with word_count_i==0: go to DONE; no writes occur.
  - start_i in any other state is ignored.
- WAIT_WORD:
  - word_ready_o=1 (decoded from state).
  - On word_valid_i & word_ready_o: latch word_i, clear the byte index, go to WRITE.
  - Without valid, stay in WAIT_WORD with mem_we_o=0.
- WRITE (4 consecutive cycles):
  - mem_we_o=1; mem_addr_o = addr pointer; mem_wdata_o = word[8*idx +: 8] for idx = 0..3.
  - The addr pointer increments by 1 every write cycle, modulo 2**ADDRESS_WIDTH (0xFF wraps to 0x00 at default width).
  - When idx=3: decrement the word counter. If the new count is 0, go to DONE; otherwise go to WAIT_WORD.
- DONE: done_o=1 for exactly one cycle, then IDLE.
- Throughput and latency:
  - 5 cycles per word minimum: 1 handshake cycle plus 4 write cycles.
  - A word accepted at edge N produces writes in cycles N+1..N+4.
  - done_o is high in the cycle after the last write.
- busy_o = cpu_hold_o = (state==WAIT_WORD or state==WRITE).
- Outputs are state-decoded; mem_addr_o and mem_wdata_o are 0 when mem_we_o=0.
- word_ready_o is never high in WRITE, so the source back-pressures and a word is never dropped.
- Word count is not checked against memory size. A load larger than the array wraps and overwrites from address 0.

Test Plan:
- Single word: start_i with base 0x10, count 1, then word 0xDEADBEEF -> writes EF@0x10, BE@0x11, AD@0x12, DE@0x13 on consecutive cycles; done_o pulses once in the next cycle; busy_o falls with done.
- Wrap-around: base 0xFE, count 1, word 0x11223344 -> writes 44@0xFE, 33@0xFF, 22@0x00, 11@0x01.
- Back-pressure and stream:
  - count 3, word_valid_i delayed 3 cycles before words 2 and 3 -> mem_we_o low while waiting; word_ready_o low during all WRITE cycles.
  - 12 writes total to base..base+11; exactly one done pulse.
- Zero count: start_i with count 0 -> no mem_we_o; done_o pulses next cycle; busy_o stays 0.
- Abort and ignore:
  - rst_n low during the third byte of a word -> next cycle mem_we_o=0, busy_o=0, state IDLE; no fourth byte is written.
  - Separately, start_i asserted during WRITE -> ignored; base and count are unchanged.
